// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - Round-robin arbiter sharing one line-wide memory port between I-cache and D-cache.
module mem_arbiter #(
    parameter int ADDR_W = 26,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              reqI_mem,
    input  logic [ADDR_W-1:0] reqAddrI_mem,
    output logic [LINE_W-1:0] instr_from_mem,
    output logic              read_ready_I,
    input  logic              reqD_mem,
    input  logic              reqD_write,
    input  logic [ADDR_W-1:0] reqAddrD_mem,
    input  logic [LINE_W-1:0] reqDataD_mem,
    output logic [LINE_W-1:0] data_from_mem_D,
    output logic              read_ready_D,
    output logic              written_data_ack_D,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY_I,
        S_BUSY_D,
        S_DONE
    } state_t;

    state_t            r_state;
    logic              r_last_i;
    logic              r_flush_flag;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [LINE_W-1:0] r_mem_wdata;
    logic [LINE_W-1:0] r_instr;
    logic [LINE_W-1:0] r_data_d;
    logic              r_rdy_i;
    logic              r_rdy_d;
    logic              r_wack_d;

    state_t            w_state_nxt;
    logic              w_last_i_nxt;
    logic              w_flush_flag_nxt;
    logic              w_mem_req_nxt;
    logic              w_mem_we_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [LINE_W-1:0] w_mem_wdata_nxt;
    logic [LINE_W-1:0] w_instr_nxt;
    logic [LINE_W-1:0] w_data_d_nxt;
    logic              w_rdy_i_nxt;
    logic              w_rdy_d_nxt;
    logic              w_wack_d_nxt;
    logic              w_grant_d;
    logic              w_grant_i;

    // D wins unless I is also pending and D was the last one served.
    assign w_grant_d = reqD_mem && (!reqI_mem || r_last_i);
    assign w_grant_i = reqI_mem && !w_grant_d;

    always_comb begin
        w_state_nxt      = r_state;
        w_last_i_nxt     = r_last_i;
        w_flush_flag_nxt = r_flush_flag;
        w_mem_req_nxt    = r_mem_req;
        w_mem_we_nxt     = r_mem_we;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_instr_nxt      = r_instr;
        w_data_d_nxt     = r_data_d;
        w_rdy_i_nxt      = 1'b0;
        w_rdy_d_nxt      = 1'b0;
        w_wack_d_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt     = S_BUSY_D;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = reqD_write;
                    w_mem_addr_nxt  = reqAddrD_mem;
                    w_mem_wdata_nxt = reqDataD_mem;
                    w_last_i_nxt    = 1'b0;
                end else if (w_grant_i) begin
                    w_state_nxt      = S_BUSY_I;
                    w_mem_req_nxt    = 1'b1;
                    w_mem_we_nxt     = 1'b0;
                    w_mem_addr_nxt   = reqAddrI_mem;
                    w_last_i_nxt     = 1'b1;
                    w_flush_flag_nxt = flush;
                end
            end
            S_BUSY_I: begin
                if (mem_ready) begin
                    w_state_nxt      = S_DONE;
                    w_mem_req_nxt    = 1'b0;
                    w_mem_we_nxt     = 1'b0;
                    w_flush_flag_nxt = 1'b0;
                    // A flushed fetch still completes at memory but is never delivered.
                    if (!r_flush_flag && !flush) begin
                        w_rdy_i_nxt = 1'b1;
                        w_instr_nxt = mem_rdata;
                    end
                end else if (flush) begin
                    w_flush_flag_nxt = 1'b1;
                end
            end
            S_BUSY_D: begin
                if (mem_ready) begin
                    w_state_nxt   = S_DONE;
                    w_mem_req_nxt = 1'b0;
                    w_mem_we_nxt  = 1'b0;
                    if (r_mem_we) begin
                        w_wack_d_nxt = 1'b1;
                    end else begin
                        w_rdy_d_nxt  = 1'b1;
                        w_data_d_nxt = mem_rdata;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_i     <= 1'b1;
            r_flush_flag <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_instr      <= '0;
            r_data_d     <= '0;
            r_rdy_i      <= 1'b0;
            r_rdy_d      <= 1'b0;
            r_wack_d     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_i     <= w_last_i_nxt;
            r_flush_flag <= w_flush_flag_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_instr      <= w_instr_nxt;
            r_data_d     <= w_data_d_nxt;
            r_rdy_i      <= w_rdy_i_nxt;
            r_rdy_d      <= w_rdy_d_nxt;
            r_wack_d     <= w_wack_d_nxt;
        end
    end

    assign mem_req            = r_mem_req;
    assign mem_we             = r_mem_we;
    assign mem_addr           = r_mem_addr;
    assign mem_wdata          = r_mem_wdata;
    assign instr_from_mem     = r_instr;
    assign data_from_mem_D    = r_data_d;
    assign read_ready_I       = r_rdy_i;
    assign read_ready_D       = r_rdy_d;
    assign written_data_ack_D = r_wack_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - Directed and randomized transaction-level checks of mem_arbiter.
module tb_mem_arbiter;
    localparam int ADDR_W = 26;
    localparam int LINE_W = 128;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              reqI_mem;
    logic [ADDR_W-1:0] reqAddrI_mem;
    logic [LINE_W-1:0] instr_from_mem;
    logic              read_ready_I;
    logic              reqD_mem;
    logic              reqD_write;
    logic [ADDR_W-1:0] reqAddrD_mem;
    logic [LINE_W-1:0] reqDataD_mem;
    logic [LINE_W-1:0] data_from_mem_D;
    logic              read_ready_D;
    logic              written_data_ack_D;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .reqI_mem(reqI_mem), .reqAddrI_mem(reqAddrI_mem),
        .instr_from_mem(instr_from_mem), .read_ready_I(read_ready_I),
        .reqD_mem(reqD_mem), .reqD_write(reqD_write), .reqAddrD_mem(reqAddrD_mem),
        .reqDataD_mem(reqDataD_mem), .data_from_mem_D(data_from_mem_D),
        .read_ready_D(read_ready_D), .written_data_ack_D(written_data_ack_D),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: which side was served last, and what each cache last received.
    bit                m_last_i;
    logic [LINE_W-1:0] m_instr;
    logic [LINE_W-1:0] m_datad;

    task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_acks(input string tag, input bit e_ri, input bit e_rd, input bit e_wa);
        check({tag, "_rdyI"}, read_ready_I, e_ri);
        check({tag, "_rdyD"}, read_ready_D, e_rd);
        check({tag, "_wackD"}, written_data_ack_D, e_wa);
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic scramble_inputs();
        reqAddrI_mem = ADDR_W'($urandom);
        reqAddrD_mem = ADDR_W'($urandom);
        reqDataD_mem = rand_line();
        reqD_write   = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        flush     = 1'b0;
        reqI_mem  = 1'b0;
        reqD_mem  = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        m_last_i = 1'b1;
        m_instr  = '0;
        m_datad  = '0;
    endtask

    // Called at a negedge with the arbiter idle and request inputs already driven.
    // fc: busy-cycle index at which flush is pulsed (lat means at the mem_ready edge), -1 for none.
    task automatic run_txn(input bit fg, input int fc, input int lat, input bit sp_done,
                           input logic [LINE_W-1:0] rd, output bit gd);
        logic [ADDR_W-1:0] e_addr;
        bit                e_we;
        logic [LINE_W-1:0] e_wdata;
        bit                supp;
        gd      = reqD_mem && (!reqI_mem || m_last_i);
        e_addr  = gd ? reqAddrD_mem : reqAddrI_mem;
        e_we    = gd ? reqD_write : 1'b0;
        e_wdata = reqDataD_mem;
        supp    = !gd && fg;
        flush   = fg;
        @(negedge clk);
        flush    = 1'b0;
        m_last_i = !gd;
        check("grant_req", mem_req, 1'b1);
        check("grant_addr", mem_addr, e_addr);
        check("grant_we", mem_we, e_we);
        if (e_we) check("grant_wdata", mem_wdata, e_wdata);
        check_acks("grant", 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < lat; c++) begin
            scramble_inputs();
            if (c == fc) begin
                flush = 1'b1;
                if (!gd) supp = 1'b1;
            end
            @(negedge clk);
            flush = 1'b0;
            check("busy_req", mem_req, 1'b1);
            check("busy_addr", mem_addr, e_addr);
            check("busy_we", mem_we, e_we);
            check_acks("busy", 1'b0, 1'b0, 1'b0);
        end
        if (fc == lat) begin
            flush = 1'b1;
            if (!gd) supp = 1'b1;
        end
        mem_ready = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        flush     = 1'b0;
        mem_ready = sp_done;
        mem_rdata = rand_line();
        if (gd && !e_we) m_datad = rd;
        if (!gd && !supp) m_instr = rd;
        check_acks("ack", !gd && !supp, gd && !e_we, gd && e_we);
        check("ack_req", mem_req, 1'b0);
        check("ack_we", mem_we, 1'b0);
        check("ack_instr", instr_from_mem, m_instr);
        check("ack_dataD", data_from_mem_D, m_datad);
        if (gd) reqD_mem = 1'b0;
        else reqI_mem = 1'b0;
        @(negedge clk);
        mem_ready = 1'b0;
        check_acks("done", 1'b0, 1'b0, 1'b0);
        check("done_req", mem_req, 1'b0);
        check("done_instr", instr_from_mem, m_instr);
        check("done_dataD", data_from_mem_D, m_datad);
    endtask

    initial begin
        bit gd;
        int lat;
        int fc;
        reqAddrI_mem = '0;
        reqAddrD_mem = '0;
        reqDataD_mem = '0;
        reqD_write   = 1'b0;

        // Reset state
        do_reset();
        reset = 1'b1;
        @(negedge clk);
        check("rst_req", mem_req, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_addr", mem_addr, '0);
        check("rst_wdata", mem_wdata, '0);
        check("rst_instr", instr_from_mem, '0);
        check("rst_dataD", data_from_mem_D, '0);
        check_acks("rst", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // I-side read alone, mem_req high for three cycles
        do_reset();
        reqI_mem     = 1'b1;
        reqAddrI_mem = 26'h0000040;
        run_txn(1'b0, -1, 2, 1'b0, {16{8'hA5}}, gd);
        check("ionly_side", gd, 1'b0);
        check("ionly_instr", instr_from_mem, {16{8'hA5}});

        // Simultaneous after reset: D write first, then I at M+2
        do_reset();
        reqI_mem     = 1'b1;
        reqAddrI_mem = 26'h0000123;
        reqD_mem     = 1'b1;
        reqD_write   = 1'b1;
        reqAddrD_mem = 26'h0000010;
        reqDataD_mem = rand_line();
        run_txn(1'b0, -1, 1, 1'b0, rand_line(), gd);
        check("both_first_d", gd, 1'b1);
        run_txn(1'b0, -1, 1, 1'b0, rand_line(), gd);
        check("both_second_i", gd, 1'b0);

        // Both held across four transactions alternate D,I,D,I
        do_reset();
        for (int k = 0; k < 4; k++) begin
            reqI_mem = 1'b1;
            reqD_mem = 1'b1;
            scramble_inputs();
            run_txn(1'b0, -1, k, 1'b0, rand_line(), gd);
            check("rr_order", gd, (k % 2) == 0);
        end

        // Flush one cycle after the I grant, then a normal D read
        do_reset();
        reqI_mem     = 1'b1;
        reqAddrI_mem = 26'h0000200;
        run_txn(1'b0, 0, 3, 1'b0, rand_line(), gd);
        check("flush_instr_kept", instr_from_mem, '0);
        reqD_mem   = 1'b1;
        reqD_write = 1'b0;
        run_txn(1'b0, -1, 1, 1'b0, {4{32'hDEADBEEF}}, gd);
        check("after_flush_dataD", data_from_mem_D, {4{32'hDEADBEEF}});

        // Reset in BUSY_D, then a stale mem_ready
        do_reset();
        reqD_mem     = 1'b1;
        reqD_write   = 1'b1;
        reqAddrD_mem = 26'h0000077;
        reqDataD_mem = rand_line();
        @(negedge clk);
        check("rstbusy_req", mem_req, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        reqD_mem  = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = rand_line();
        @(negedge clk);
        mem_ready = 1'b0;
        check("rstbusy_req0", mem_req, 1'b0);
        check("rstbusy_we0", mem_we, 1'b0);
        check("rstbusy_addr0", mem_addr, '0);
        check("rstbusy_wdata0", mem_wdata, '0);
        check("rstbusy_dataD0", data_from_mem_D, '0);
        check_acks("rstbusy", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_acks("rstbusy2", 1'b0, 1'b0, 1'b0);
        check("rstbusy_req1", mem_req, 1'b0);
        m_last_i = 1'b1;
        m_instr  = '0;
        m_datad  = '0;

        // Randomized traffic with spurious mem_ready in IDLE and DONE
        for (int t = 0; t < 60; t++) begin
            if (!reqI_mem && !reqD_mem && $urandom_range(0, 2) == 0) begin
                mem_ready = 1'b1;
                mem_rdata = rand_line();
                @(negedge clk);
                mem_ready = 1'b0;
                check("idle_req", mem_req, 1'b0);
                check("idle_instr", instr_from_mem, m_instr);
                check("idle_dataD", data_from_mem_D, m_datad);
                check_acks("idle", 1'b0, 1'b0, 1'b0);
            end
            if (!reqI_mem) reqI_mem = 1'($urandom_range(0, 1));
            if (!reqD_mem) reqD_mem = 1'($urandom_range(0, 1));
            if (!reqI_mem && !reqD_mem) begin
                if ($urandom_range(0, 1) == 1) reqI_mem = 1'b1;
                else reqD_mem = 1'b1;
            end
            scramble_inputs();
            lat = $urandom_range(0, 4);
            fc  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, lat)) : -1;
            run_txn($urandom_range(0, 4) == 0, fc, lat, 1'($urandom_range(0, 1)), rand_line(), gd);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
